// File: rtl/convolution_coprocessor_pkg.sv
// Shared types and constants for the convolution coprocessor accumulator slice.
// Holds the accumulator FSM state encoding, the default datapath widths and a
// helper that produces the signed saturation bounds for any width.
package convolution_coprocessor_pkg;

    localparam int CONV_DATA_WIDTH = 22;
    localparam int CONV_ACC_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } convState_e;

    // Largest (wantMax=1) or smallest (wantMax=0) signed value representable
    // in 'width' bits, returned sign-extended to 64 bits.
    function automatic logic signed [63:0] satBound(input int unsigned width, input logic wantMax);
        logic signed [63:0] one;
        one = 64'sd1;
        if (wantMax) begin
            return (one <<< (width - 1)) - 64'sd1;
        end
        return -(one <<< (width - 1));
    endfunction

endpackage

// File: rtl/convolution_coprocessor_sat_adder.sv
// Combinational saturating adder: adds a pre-extended sample to the running
// accumulator one bit wider than the accumulator, then clamps to the signed
// ACC_WIDTH range and flags when the clamp engaged.
module convolution_coprocessor_sat_adder
    import convolution_coprocessor_pkg::*;
#(
    parameter int ACC_WIDTH = CONV_ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    input  logic [ACC_WIDTH:0]   sample_i,
    output logic [ACC_WIDTH-1:0] sum_o,
    output logic                 sat_o
);

    localparam logic signed [63:0] MAX_64 = satBound(ACC_WIDTH, 1'b1);
    localparam logic signed [63:0] MIN_64 = satBound(ACC_WIDTH, 1'b0);
    localparam logic signed [ACC_WIDTH:0] MAX_EXT = MAX_64[ACC_WIDTH:0];
    localparam logic signed [ACC_WIDTH:0] MIN_EXT = MIN_64[ACC_WIDTH:0];

    logic signed [ACC_WIDTH:0] sumWide;

    assign sumWide = $signed({acc_i[ACC_WIDTH-1], acc_i}) + $signed(sample_i);

    // Clamp the one-bit-wider sum back into the accumulator range.
    always_comb begin
        sum_o = sumWide[ACC_WIDTH-1:0];
        sat_o = 1'b0;
        if (sumWide > MAX_EXT) begin
            sum_o = MAX_EXT[ACC_WIDTH-1:0];
            sat_o = 1'b1;
        end else if (sumWide < MIN_EXT) begin
            sum_o = MIN_EXT[ACC_WIDTH-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/convolution_coprocessor_accumulator.sv
// Sequential signed accumulator for one convolution output tap. A job is
// started with a term count, samples arrive over a valid/ready handshake and
// are summed with saturation, and the result is held on a valid/ready output
// until the consumer takes it. A zero-length job produces a zero result.
module convolution_coprocessor_accumulator
    import convolution_coprocessor_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_DATA_WIDTH,
    parameter int ACC_WIDTH  = CONV_ACC_WIDTH,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [ACC_WIDTH-1:0]  result_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic                  overflow_o,
    output logic                  busy_o
);

    convState_e            state_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic [LEN_WIDTH-1:0]  count_q;
    logic                  sticky_q;
    logic [ACC_WIDTH-1:0]  result_q;
    logic                  resultValid_q;
    logic                  overflow_q;

    logic [ACC_WIDTH:0]    sampleExt;
    logic [ACC_WIDTH-1:0]  accNext_d;
    logic                  addSat_d;

    assign sampleExt = {{(ACC_WIDTH + 1 - DATA_WIDTH){data_i[DATA_WIDTH-1]}}, data_i};

    convolution_coprocessor_sat_adder #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_satAdder (
        .acc_i    (acc_q),
        .sample_i (sampleExt),
        .sum_o    (accNext_d),
        .sat_o    (addSat_d)
    );

    assign ready_o        = (state_q == ACCUM);
    assign busy_o         = (state_q != IDLE);
    assign result_o       = result_q;
    assign result_valid_o = resultValid_q;
    assign overflow_o     = overflow_q;

    // Job FSM: launch on start in IDLE, accumulate accepted samples, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            count_q       <= '0;
            sticky_q      <= 1'b0;
            result_q      <= '0;
            resultValid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            acc_q    <= '0;
                            count_q  <= len_i;
                            sticky_q <= 1'b0;
                            state_q  <= ACCUM;
                        end else begin
                            result_q      <= '0;
                            overflow_q    <= 1'b0;
                            resultValid_q <= 1'b1;
                            state_q       <= HOLD;
                        end
                    end
                end
                ACCUM: begin
                    if (valid_i) begin
                        acc_q    <= accNext_d;
                        count_q  <= count_q - LEN_WIDTH'(1);
                        sticky_q <= sticky_q | addSat_d;
                        if (count_q == LEN_WIDTH'(1)) begin
                            result_q      <= accNext_d;
                            overflow_q    <= sticky_q | addSat_d;
                            resultValid_q <= 1'b1;
                            state_q       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (result_ready_i) begin
                        resultValid_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_convolution_coprocessor_accumulator.sv
// Self-checking bench for the convolution accumulator. Runs directed jobs and
// randomized jobs against a plain-arithmetic reference sum with clamping. The
// accumulator is built 24 bits wide so that saturation is reachable with
// 22-bit samples and at most 63 terms.
module tb_convolution_coprocessor_accumulator;

    localparam int DW = 22;
    localparam int AW = 24;
    localparam int LW = 6;
    localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (AW - 1));

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [LW-1:0] len_i;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [AW-1:0] result_o;
    logic          result_valid_o;
    logic          result_ready_i;
    logic          overflow_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;
    longint samples[$];

    convolution_coprocessor_accumulator #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .len_i          (len_i),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .overflow_o     (overflow_o),
        .busy_o         (busy_o)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Advance one rising edge and return on the following falling edge, where outputs are sampled.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: running signed sum of the first len samples, clamped after every add.
    function automatic void modelJob(input int len, output longint sum, output bit ovf);
        sum = 0;
        ovf = 1'b0;
        for (int i = 0; i < len; i++) begin
            sum = sum + samples[i];
            if (sum > MAXV) begin
                sum = MAXV;
                ovf = 1'b1;
            end else if (sum < MINV) begin
                sum = MINV;
                ovf = 1'b1;
            end
        end
    endfunction

    // One full job: start, feed samples with gap idle cycles before each
    // (gap<0 picks 0..2 at random), hold the result holdCycles cycles, then take it.
    task automatic applyStimulus(input int len, input int gap, input int holdCycles, input bit pokeStart);
        longint expSum;
        bit     expOvf;
        int     g;
        modelJob(len, expSum, expOvf);
        checkOutput("idle_busy", longint'(busy_o), 0);
        checkOutput("idle_ready", longint'(ready_o), 0);
        checkOutput("idle_result_valid", longint'(result_valid_o), 0);
        start_i = 1'b1;
        len_i   = LW'(len);
        tick();
        start_i = 1'b0;
        len_i   = '0;
        for (int i = 0; i < len; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
                valid_i = 1'b0;
                checkOutput("stall_ready", longint'(ready_o), 1);
                checkOutput("stall_busy", longint'(busy_o), 1);
                checkOutput("stall_result_valid", longint'(result_valid_o), 0);
                tick();
            end
            valid_i = 1'b1;
            data_i  = DW'(samples[i]);
            checkOutput("accum_ready", longint'(ready_o), 1);
            checkOutput("accum_result_valid", longint'(result_valid_o), 0);
            if (pokeStart && i == 0) begin
                start_i = 1'b1;
                len_i   = LW'(9);
            end
            tick();
            valid_i = 1'b0;
            start_i = 1'b0;
            len_i   = '0;
        end
        for (int h = 0; h <= holdCycles; h++) begin
            checkOutput("hold_result_valid", longint'(result_valid_o), 1);
            checkOutput("hold_result", longint'($signed(result_o)), expSum);
            checkOutput("hold_overflow", longint'(overflow_o), longint'(expOvf));
            checkOutput("hold_ready", longint'(ready_o), 0);
            checkOutput("hold_busy", longint'(busy_o), 1);
            result_ready_i = (h == holdCycles);
            tick();
        end
        result_ready_i = 1'b0;
        checkOutput("done_result_valid", longint'(result_valid_o), 0);
        checkOutput("done_busy", longint'(busy_o), 0);
        checkOutput("done_ready", longint'(ready_o), 0);
    endtask

    // Directed test plan followed by randomized jobs.
    initial begin
        int len;
        rst            = 1'b1;
        start_i        = 1'b0;
        len_i          = '0;
        data_i         = '0;
        valid_i        = 1'b0;
        result_ready_i = 1'b0;
        @(negedge clk);
        tick();
        tick();
        checkOutput("reset_busy", longint'(busy_o), 0);
        checkOutput("reset_ready", longint'(ready_o), 0);
        checkOutput("reset_result_valid", longint'(result_valid_o), 0);
        checkOutput("reset_result", longint'($signed(result_o)), 0);
        checkOutput("reset_overflow", longint'(overflow_o), 0);
        rst = 1'b0;
        tick();

        $display("[TB] basic back-to-back sum");
        samples = '{5, -2, 10};
        applyStimulus(3, 0, 0, 1'b0);

        $display("[TB] bubbles and output backpressure");
        samples = '{100, 200, -50, 1};
        applyStimulus(4, 2, 5, 1'b0);

        $display("[TB] zero-length job");
        samples = '{};
        applyStimulus(0, 0, 2, 1'b0);

        $display("[TB] positive saturation");
        samples = '{2097151, 2097151, 2097151, 2097151, 2097151};
        applyStimulus(5, 0, 1, 1'b0);

        $display("[TB] negative saturation");
        samples = '{-2097152, -2097152, -2097152, -2097152, -2097152};
        applyStimulus(5, 1, 0, 1'b0);

        $display("[TB] reset mid-job");
        start_i = 1'b1;
        len_i   = LW'(4);
        tick();
        start_i = 1'b0;
        len_i   = '0;
        valid_i = 1'b1;
        data_i  = DW'(3);
        tick();
        data_i  = DW'(4);
        tick();
        valid_i = 1'b0;
        checkOutput("midjob_busy", longint'(busy_o), 1);
        rst = 1'b1;
        tick();
        checkOutput("midreset_busy", longint'(busy_o), 0);
        checkOutput("midreset_ready", longint'(ready_o), 0);
        checkOutput("midreset_result_valid", longint'(result_valid_o), 0);
        checkOutput("midreset_result", longint'($signed(result_o)), 0);
        checkOutput("midreset_overflow", longint'(overflow_o), 0);
        rst = 1'b0;
        tick();
        samples = '{7};
        applyStimulus(1, 0, 0, 1'b0);

        $display("[TB] start ignored during accumulation");
        samples = '{1, 1};
        applyStimulus(2, 1, 0, 1'b1);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 12; j++) begin
            len = (j == 11) ? 63 : int'($urandom_range(0, 12));
            samples = '{};
            for (int i = 0; i < len; i++) begin
                samples.push_back(longint'($urandom_range(0, 4194303)) - 64'sd2097152);
            end
            applyStimulus(len, -1, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/convolution_coprocessor_accumulator.md
Name: convolution_coprocessor_accumulator

Overview:
- Sequential signed accumulator for the convolution coprocessor; performs the add-direction counterpart of the datapath subtractor.
- Sums a programmed number of signed DATA_WIDTH samples (products of one output tap) into a saturating ACC_WIDTH result.
- Sits between the product stage and the result buffer. Valid/ready handshake on input, valid/ready handshake on output.

Parameters:
- DATA_WIDTH, 22, width of each signed 2's-complement input sample.
- ACC_WIDTH, 32, width of the signed accumulator and result; must be >= DATA_WIDTH.
- LEN_WIDTH, 6, width of the term-count field; up to 2^LEN_WIDTH-1 terms per job.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle job start; honoured only in IDLE.
- len_i  in  LEN_WIDTH  number of samples in the job; sampled with start_i.
- data_i  in  DATA_WIDTH  signed input sample.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  accumulator accepts a sample this cycle.
- result_o  out  ACC_WIDTH  signed accumulated sum; stable while result_valid_o=1.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  consumer takes the result.
- overflow_o  out  1  the current job saturated at least once; valid with result_valid_o.
- busy_o  out  1  state is not IDLE.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- Reset (any state, including mid-job):
  - state=IDLE.
  - Accumulator, count, result_o, result_valid_o, overflow_o, ready_o and busy_o all cleared to 0.
  - A partially accumulated job is discarded.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - ready_o=0.
  - On start_i with len_i>0: acc<=0, count<=len_i, overflow<=0, next state ACCUM.
  - On start_i with len_i=0: result_o<=0, overflow_o<=0, next state HOLD. result_valid_o rises the next cycle.
- ACCUM:
  - ready_o=1 combinationally from state only; it does not depend on valid_i.
  - A sample is transferred on the edge where valid_i && ready_o.
  - On transfer: acc <= sat(acc + sext(data_i)); count decrements.
  - valid_i=0 cycles stall with no change to state, acc or count.
  - On the transfer with count==1: result_o <= sat sum including that sample, overflow_o <= sticky flag OR that add's saturation, next state HOLD.
  - Latency: result_valid_o=1 in the cycle after the last sample is accepted.
- HOLD:
  - result_valid_o=1, ready_o=0.
  - result_o and overflow_o are held until result_valid_o && result_ready_i. On that handshake, next state IDLE and result_valid_o drops the following cycle.
- start_i outside IDLE is ignored and not queued. The earliest new job is start_i in the first IDLE cycle after HOLD.
- Arithmetic:
  - Inputs are sign-extended to ACC_WIDTH+1 bits and added to the sign-extended accumulator.
  - If the sum exceeds 2^(ACC_WIDTH-1)-1, clamp to that value. If it is below -2^(ACC_WIDTH-1), clamp to that value.
  - Each clamp sets the sticky overflow flag. A later in-range sum does not clear the flag. Accumulation continues from the clamped value.
- busy_o=1 in ACCUM and HOLD.

Decomposition:
- Package convolution_coprocessor_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - default width constants CONV_DATA_WIDTH=22 and CONV_ACC_WIDTH=32;
  - a function returning the signed max/min values for a given width.
- One sub-module, convolution_coprocessor_sat_adder: combinational, ACC_WIDTH-parameterised. Inputs are acc and the sign-extended sample; outputs are the saturated sum and a sat flag.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Basic sum, back-to-back valid: start_i with len_i=3, then samples 5, -2, 10 -> ready_o high for 3 cycles; result_o=13 one cycle after the third accept; overflow_o=0.
- Bubbles and output backpressure: len_i=4, samples 100, 200, -50, 1 with valid_i low for 2 cycles between each, result_ready_i held low 5 cycles -> result_o=251 held stable; result_valid_o=1 for all 5 cycles; IDLE one cycle after result_ready_i rises.
- Zero-length job: start_i with len_i=0 -> HOLD with result_o=0 next cycle; ready_o never asserts.
- Saturation (ACC_WIDTH=24 override): len_i=5, each sample 2097151 -> result_o=8388607, overflow_o=1. Negative case: len_i=5, each sample -2097152 -> result_o=-8388608, overflow_o=1.
- Reset mid-job: len_i=4, two samples accepted, then rst pulsed for one cycle -> all outputs 0 and busy_o=0 next cycle. A new job with len_i=1 and sample 7 -> result_o=7.
- Ignored start: start_i pulsed during ACCUM with len_i=9 for a len_i=2 job with samples 1, 1 -> result_o=2 after exactly 2 accepts; return to IDLE.
